// File: rtl/dac_pkg.sv
// Shared state encoding and default timing for the AD5541-class serial DAC writer.
package dac_pkg;

   localparam int unsigned DAC_BITS       = 16;
   localparam int unsigned DAC_SCLK_DIV   = 4;
   localparam int unsigned DAC_CS_SETUP   = 2;
   localparam int unsigned DAC_CS_HOLD    = 1;
   localparam int unsigned DAC_LDAC_WIDTH = 3;

   typedef enum logic [5:0] {
      ST_IDLE  = 6'b000001,
      ST_SETUP = 6'b000010,
      ST_SHIFT = 6'b000100,
      ST_HOLD  = 6'b001000,
      ST_LOAD  = 6'b010000,
      ST_DONE  = 6'b100000
   } dac_state_t;

   function automatic int unsigned dac_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// Half-period divider for the DAC serial clock: idles low, toggles every DIV enabled
// cycles, and flags the clock edge on which sclk will rise or fall.
module dac_sclk_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_sclk,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_sclk;
   logic          w_term;

   assign w_term = i_en && (r_cnt == CW'(DIV - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_en) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (w_term) begin
         r_cnt  <= '0;
         r_sclk <= ~r_sclk;
      end else begin
         r_cnt  <= r_cnt + CW'(1);
      end
   end

   // Strobes mark the cycle whose closing edge moves sclk.
   assign o_sclk = r_sclk;
   assign o_rise = w_term & ~r_sclk;
   assign o_fall = w_term &  r_sclk;

endmodule

// File: rtl/dac5541_tx.sv
// Serial write controller for a 16-bit LDAC-style voltage DAC: frames a parallel code
// MSB-first under dac_cs, strobes dac_ldac, and queues one pending code.
module dac5541_tx
   import dac_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DAC_BITS,
   parameter int unsigned SCLK_DIV   = DAC_SCLK_DIV,
   parameter int unsigned CS_SETUP   = DAC_CS_SETUP,
   parameter int unsigned CS_HOLD    = DAC_CS_HOLD,
   parameter int unsigned LDAC_WIDTH = DAC_LDAC_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] dac_data,
   input  logic                 dac_start,
   output logic                 dac_cs,
   output logic                 dac_sclk,
   output logic                 dac_sdi,
   output logic                 dac_ldac,
   output logic                 dac_busy,
   output logic                 dac_done,
   output logic                 dac_ovf
);

   localparam int unsigned CNT_MAX = dac_max(dac_max(CS_SETUP, CS_HOLD),
                                             dac_max(LDAC_WIDTH, 2 * DATA_BITS));
   localparam int unsigned CW      = $clog2(CNT_MAX + 1);

   dac_state_t           r_state, w_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [CW-1:0]        r_bit, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shreg, r_pend, w_pend_nxt, w_load_data;
   logic                 r_pend_vld, w_pend_vld_nxt;
   logic                 w_load, w_shift, w_ovf;
   logic                 w_sclk_en, w_sclk, w_rise, w_fall;
   logic                 r_cs, r_ldac, r_busy, r_done, r_ovf;

   assign w_sclk_en = (r_state == ST_SHIFT);

   dac_sclk_gen #(
      .DIV (SCLK_DIV)
   ) u_sclk_gen (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_sclk_en),
      .o_sclk (w_sclk),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   always_comb begin
      w_nxt          = r_state;
      w_cnt_nxt      = r_cnt;
      w_bit_nxt      = r_bit;
      w_load         = 1'b0;
      w_load_data    = r_pend;
      w_pend_nxt     = r_pend;
      w_pend_vld_nxt = r_pend_vld;
      w_shift        = 1'b0;
      w_ovf          = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            w_bit_nxt = '0;
            // A queued code launches first; a coincident start refills the queue.
            if (r_pend_vld) begin
               w_load         = 1'b1;
               w_load_data    = r_pend;
               w_nxt          = ST_SETUP;
               w_pend_vld_nxt = dac_start;
               if (dac_start) w_pend_nxt = dac_data;
            end else if (dac_start) begin
               w_load      = 1'b1;
               w_load_data = dac_data;
               w_nxt       = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (r_cnt == CW'(CS_SETUP - 1)) begin
               w_cnt_nxt = '0;
               w_nxt     = ST_SHIFT;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_SHIFT: begin
            if (w_rise) w_bit_nxt = r_bit + CW'(1);
            if (w_fall) begin
               w_shift = 1'b1;
               if (r_bit == CW'(DATA_BITS)) begin
                  w_bit_nxt = '0;
                  w_nxt     = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (r_cnt == CW'(CS_HOLD - 1)) begin
               w_cnt_nxt = '0;
               w_nxt     = ST_LOAD;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_LOAD: begin
            if (r_cnt == CW'(LDAC_WIDTH - 1)) begin
               w_cnt_nxt = '0;
               w_nxt     = ST_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_DONE: w_nxt = ST_IDLE;
         default: w_nxt = ST_IDLE;
      endcase

      if (dac_start && (r_state != ST_IDLE)) begin
         w_pend_nxt     = dac_data;
         w_pend_vld_nxt = 1'b1;
         w_ovf          = r_pend_vld;
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_bit      <= '0;
         r_shreg    <= '0;
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_cs       <= 1'b1;
         r_ldac     <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_cnt      <= w_cnt_nxt;
         r_bit      <= w_bit_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         if (w_load) begin
            r_shreg <= w_load_data;
         end else if (w_shift) begin
            r_shreg <= {r_shreg[DATA_BITS-2:0], 1'b0};
         end
         r_cs   <= !((w_nxt == ST_SETUP) || (w_nxt == ST_SHIFT) || (w_nxt == ST_HOLD));
         r_ldac <= (w_nxt != ST_LOAD);
         r_busy <= (w_nxt != ST_IDLE) || w_pend_vld_nxt;
         r_done <= (w_nxt == ST_DONE);
         r_ovf  <= w_ovf;
      end
   end

   assign dac_cs   = r_cs;
   assign dac_sclk = w_sclk;
   assign dac_sdi  = r_shreg[DATA_BITS-1];
   assign dac_ldac = r_ldac;
   assign dac_busy = r_busy;
   assign dac_done = r_done;
   assign dac_ovf  = r_ovf;

endmodule

// File: tb/tb_dac5541_tx.sv
// Self-checking bench for dac5541_tx: timeline model of frames and the pending slot,
// directed scenarios with literal expectations, random traffic, and bus invariants.
module tb_dac5541_tx;

   localparam int B       = 16;
   localparam int DIV     = 4;
   localparam int SET     = 2;
   localparam int HLD     = 1;
   localparam int LDW     = 3;
   localparam int T_SHIFT = 2 * B * DIV;
   localparam int T_CS    = SET + T_SHIFT + HLD;
   localparam int T_TOT   = T_CS + LDW + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] dac_data = '0;
   logic        dac_start = 1'b0;

   logic cs0, sclk0, sdi0, ldac0, busy0, done0, ovf0;
   logic cs1, sclk1, sdi1, ldac1, busy1, done1, ovf1;

   dac5541_tx u_dut0 (
      .clk(clk), .reset(reset), .dac_data(dac_data), .dac_start(dac_start),
      .dac_cs(cs0), .dac_sclk(sclk0), .dac_sdi(sdi0), .dac_ldac(ldac0),
      .dac_busy(busy0), .dac_done(done0), .dac_ovf(ovf0)
   );

   dac5541_tx #(.SCLK_DIV(1)) u_dut1 (
      .clk(clk), .reset(reset), .dac_data(dac_data), .dac_start(dac_start),
      .dac_cs(cs1), .dac_sclk(sclk1), .dac_sdi(sdi1), .dac_ldac(ldac1),
      .dac_busy(busy1), .dac_done(done1), .dac_ovf(ovf1)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {cs,sclk,sdi,ldac,done} at offset t from the first cs-low cycle.
   function automatic logic [4:0] frame_out(input int t, input logic [15:0] code);
      logic cs, sc, sd, ld, dn;
      int   bi;
      cs = (t < T_CS) ? 1'b0 : 1'b1;
      sc = 1'b0;
      if (t >= SET && t < SET + T_SHIFT) sc = (((t - SET) % (2 * DIV)) >= DIV);
      bi = (t < SET) ? 0 : (t - SET) / (2 * DIV);
      sd = (bi < B) ? code[B - 1 - bi] : 1'b0;
      ld = !(t >= T_CS && t < T_CS + LDW);
      dn = (t == T_CS + LDW);
      return {cs, sc, sd, ld, dn};
   endfunction

   int          cyc = 0;
   int          m_c, m_start;
   logic        m_act = 1'b0, m_pv = 1'b0, m_idle, m_ovf, e_busy;
   logic [15:0] m_code, m_pc;
   logic [4:0]  e;
   logic [15:0] m_sent[$];

   logic        p_sclk0 = 1'b0, p_cs0 = 1'b1, p_ldac0 = 1'b1, p_sdi0 = 1'b0;
   logic        p_sdi1 = 1'b0;
   logic [15:0] cap_w = '0;
   int          cap_n = 0, cs_lo = 0, ld_lo = 0, rise_cnt = 0;
   logic [15:0] got_w[$];
   int          got_bits[$], got_cslen[$], got_ld[$], done_cyc[$], ovf_cyc[$];

   always @(posedge clk) begin
      m_c = cyc;
      cyc = cyc + 1;
      m_ovf = 1'b0;
      if (!reset) begin
         m_act = 1'b0;
         m_pv  = 1'b0;
      end else begin
         m_idle = !m_act || (m_c >= m_start + T_TOT);
         if (m_idle && m_pv) begin
            m_act = 1'b1; m_start = m_c + 1; m_code = m_pc; m_sent.push_back(m_pc);
            m_pv = dac_start;
            if (dac_start) m_pc = dac_data;
         end else if (m_idle && dac_start) begin
            m_act = 1'b1; m_start = m_c + 1; m_code = dac_data; m_sent.push_back(dac_data);
         end else if (dac_start) begin
            m_ovf = m_pv;
            m_pc  = dac_data;
            m_pv  = 1'b1;
         end
      end
      #1;
      if (m_act && cyc < m_start + T_TOT) begin
         e      = frame_out(cyc - m_start, m_code);
         e_busy = 1'b1;
      end else begin
         e      = 5'b10010;
         e_busy = m_pv;
      end
      chk("dut0 {cs,sclk,sdi,ldac,busy,done,ovf}",
          32'({cs0, sclk0, sdi0, ldac0, busy0, done0, ovf0}),
          32'({e[4], e[3], e[2], e[1], e_busy, e[0], m_ovf}));

      if (!reset) begin
         cap_n = 0; cs_lo = 0; ld_lo = 0;
      end else begin
         if (sclk0 && !p_sclk0) begin
            cap_w = {cap_w[14:0], sdi0};
            cap_n++;
            rise_cnt++;
         end
         if (!cs0) cs_lo++;
         if (cs0 && !p_cs0) begin
            got_w.push_back(cap_w); got_bits.push_back(cap_n); got_cslen.push_back(cs_lo);
            cap_n = 0; cs_lo = 0;
         end
         if (!ldac0) ld_lo++;
         if (ldac0 && !p_ldac0) begin
            got_ld.push_back(ld_lo);
            ld_lo = 0;
         end
         if (done0) done_cyc.push_back(cyc);
         if (ovf0)  ovf_cyc.push_back(cyc);
      end

      chk("inv0 sdi moved with sclk high", 32'(sclk0 && (sdi0 != p_sdi0)), 32'(0));
      chk("inv0 sclk high with cs high",   32'(sclk0 && cs0), 32'(0));
      chk("inv0 ldac low with cs low",     32'(!ldac0 && !cs0), 32'(0));
      chk("inv1 sdi moved with sclk high", 32'(sclk1 && (sdi1 != p_sdi1)), 32'(0));
      chk("inv1 sclk high with cs high",   32'(sclk1 && cs1), 32'(0));
      chk("inv1 ldac low with cs low",     32'(!ldac1 && !cs1), 32'(0));

      p_sclk0 = sclk0; p_cs0 = cs0; p_ldac0 = ldac0; p_sdi0 = sdi0; p_sdi1 = sdi1;
   end

   task automatic send(input logic [15:0] code);
      dac_data  = code;
      dac_start = 1'b1;
      @(negedge clk);
      dac_start = 1'b0;
      dac_data  = 16'($urandom);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy0 || busy1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait idle timeout", 32'(busy0 || busy1), 32'(0));
      @(negedge clk);
   endtask

   task automatic clear_logs();
      got_w.delete(); got_bits.delete(); got_cslen.delete(); got_ld.delete();
      done_cyc.delete(); ovf_cyc.delete(); m_sent.delete();
      rise_cnt = 0;
   endtask

   int s, s3, n;

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset dut0 outputs", 32'({cs0, sclk0, sdi0, ldac0, busy0, done0, ovf0}), 32'(7'b1001000));
      chk("reset dut1 outputs", 32'({cs1, sclk1, sdi1, ldac1, busy1, done1, ovf1}), 32'(7'b1001000));
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Single frame with literal timing
      clear_logs();
      s = cyc;
      send(16'hA5C3);
      wait_idle(400);
      chk("T1 frames", 32'(got_w.size()), 32'(1));
      if (got_w.size() >= 1) begin
         chk("T1 word",       32'(got_w[0]), 32'(16'hA5C3));
         chk("T1 bits",       32'(got_bits[0]), 32'(16));
         chk("T1 cs low len", 32'(got_cslen[0]), 32'(131));
      end
      chk("T1 ldac pulses", 32'(got_ld.size()), 32'(1));
      if (got_ld.size() >= 1) chk("T1 ldac len", 32'(got_ld[0]), 32'(3));
      chk("T1 done count", 32'(done_cyc.size()), 32'(1));
      if (done_cyc.size() >= 1) chk("T1 done latency", 32'(done_cyc[0] - s), 32'(135));
      chk("T1 busy after", 32'(busy0), 32'(0));

      // Back-to-back starts, second queued
      clear_logs();
      send(16'hFFFF);
      send(16'h0000);
      wait_idle(600);
      chk("T2 frames", 32'(got_w.size()), 32'(2));
      if (got_w.size() >= 2) begin
         chk("T2 word0", 32'(got_w[0]), 32'(16'hFFFF));
         chk("T2 word1", 32'(got_w[1]), 32'(16'h0000));
      end
      chk("T2 done count", 32'(done_cyc.size()), 32'(2));
      if (done_cyc.size() >= 2) chk("T2 done spacing", 32'(done_cyc[1] - done_cyc[0]), 32'(136));
      chk("T2 ovf count", 32'(ovf_cyc.size()), 32'(0));

      // Three starts in one frame: middle code is overwritten
      clear_logs();
      send(16'h1111);
      repeat (10) @(negedge clk);
      send(16'h2222);
      repeat (10) @(negedge clk);
      s3 = cyc;
      send(16'h3333);
      wait_idle(600);
      chk("T3 frames", 32'(got_w.size()), 32'(2));
      if (got_w.size() >= 2) begin
         chk("T3 word0", 32'(got_w[0]), 32'(16'h1111));
         chk("T3 word1", 32'(got_w[1]), 32'(16'h3333));
      end
      chk("T3 ovf count", 32'(ovf_cyc.size()), 32'(1));
      if (ovf_cyc.size() >= 1) chk("T3 ovf cycle", 32'(ovf_cyc[0] - s3), 32'(1));

      // Reset at the 7th sclk rise aborts the frame
      clear_logs();
      send(16'hDEAD);
      n = 0;
      while (rise_cnt < 7 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("T4 reached 7th rise", 32'(rise_cnt), 32'(7));
      reset = 1'b0;
      #1;
      chk("T4 abort dut0 outputs", 32'({cs0, sclk0, sdi0, ldac0, busy0, done0, ovf0}), 32'(7'b1001000));
      chk("T4 abort dut1 outputs", 32'({cs1, sclk1, sdi1, ldac1, busy1, done1, ovf1}), 32'(7'b1001000));
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (200) @(negedge clk);
      chk("T4 no done after abort", 32'(done_cyc.size()), 32'(0));
      chk("T4 no ldac after abort", 32'(got_ld.size()), 32'(0));
      clear_logs();
      send(16'h5A3C);
      wait_idle(400);
      chk("T4 clean frames", 32'(got_w.size()), 32'(1));
      if (got_w.size() >= 1) chk("T4 clean word", 32'(got_w[0]), 32'(16'h5A3C));
      chk("T4 clean done", 32'(done_cyc.size()), 32'(1));

      // Start coincident with a pending launch in the IDLE cycle
      clear_logs();
      s = cyc;
      send(16'hC0DE);
      repeat (5) @(negedge clk);
      send(16'hBEEF);
      n = 0;
      while (cyc < s + 136 && n < 300) begin
         @(negedge clk);
         n++;
      end
      send(16'h1234);
      wait_idle(800);
      chk("T5 frames", 32'(got_w.size()), 32'(3));
      if (got_w.size() >= 3) begin
         chk("T5 word0", 32'(got_w[0]), 32'(16'hC0DE));
         chk("T5 word1", 32'(got_w[1]), 32'(16'hBEEF));
         chk("T5 word2", 32'(got_w[2]), 32'(16'h1234));
      end
      chk("T5 ovf count", 32'(ovf_cyc.size()), 32'(0));

      // Random traffic against the model
      clear_logs();
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 160)) @(negedge clk);
         send(16'($urandom));
      end
      wait_idle(1000);
      chk("RND frame count", 32'(got_w.size()), 32'(m_sent.size()));
      for (int i = 0; i < got_w.size() && i < m_sent.size(); i++)
         chk("RND word", 32'(got_w[i]), 32'(m_sent[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
